// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared state encoding, run-status codes and defaults for the run controller.
// Latency: n/a (types, constants and a pure priority function only).
// Backpressure: n/a.
package cpu_run_pkg;

    localparam int          CNT_W             = 32;
    localparam logic [31:0] CNT_MAX           = 32'hFFFF_FFFF;
    localparam int          DEFAULT_EXIT_CODE = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_RST = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        STATUS_NONE      = 3'd0,
        STATUS_EXIT      = 3'd1,
        STATUS_HALT_PC   = 3'd2,
        STATUS_SELF_LOOP = 3'd3,
        STATUS_TIMEOUT   = 3'd4
    } status_t;

    // Resolve coincident end-of-run conditions: EXIT > HALT_PC > SELF_LOOP > TIMEOUT.
    function automatic status_t pick_status(
        input logic exit_hit,
        input logic halt_hit,
        input logic loop_hit,
        input logic tmo_hit
    );
        status_t s;
        s = STATUS_NONE;
        if (exit_hit)      s = STATUS_EXIT;
        else if (halt_hit) s = STATUS_HALT_PC;
        else if (loop_hit) s = STATUS_SELF_LOOP;
        else if (tmo_hit)  s = STATUS_TIMEOUT;
        return s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: 32-bit up-counter with clear and enable that sticks at all-ones.
// Latency: count reflects clear/enable one cycle after they are sampled.
// Backpressure: none; enable is honoured every cycle, clear wins over enable.
module sat_counter
    import cpu_run_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    // Count up while enabled, hold once saturated, clear on demand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/cpu_run_control.sv
// cpu_run_control: sequences CPU reset, run and stop; detects exit/halt-pc/self-loop/timeout.
// Latency: start -> CPU_RST next edge; end condition in a RUN cycle -> DONE at the following edge.
// Backpressure: none; start is only accepted in IDLE or DONE and dropped elsewhere.
module cpu_run_control
    import cpu_run_pkg::*;
#(
    parameter int PC_W            = 32,
    parameter int CPU_RST_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES  = 100,
    parameter int SELF_LOOP_LIMIT = 4,
    parameter int EXIT_CODE       = DEFAULT_EXIT_CODE
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] pc,
    input  logic            instr_retire,
    input  logic            syscall,
    input  logic [31:0]     v0,
    input  logic            halt_pc_en,
    input  logic [PC_W-1:0] halt_pc,
    output logic            cpu_reset,
    output logic            running,
    output logic            done,
    output logic [2:0]      status,
    output logic [31:0]     cycle_count,
    output logic [31:0]     instr_count
);

    localparam int RST_CNT_W = (CPU_RST_CYCLES > 1) ? $clog2(CPU_RST_CYCLES) : 1;
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(CPU_RST_CYCLES - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] LOOP_LIM  = 32'(SELF_LOOP_LIMIT);
    localparam logic [31:0] EXIT_V0   = 32'(EXIT_CODE);

    state_t                state, state_nxt;
    status_t               status_q, status_nxt;
    logic [RST_CNT_W-1:0]  rst_cnt, rst_cnt_nxt;

    // Self-loop tracker: last retired pc and how many times in a row it retired.
    logic [PC_W-1:0]       last_pc;
    logic                  loop_vld;
    logic [31:0]           loop_cnt, loop_cnt_nxt;

    logic                  in_run;
    logic                  start_acc;
    logic                  exit_hit, halt_hit, loop_hit, tmo_hit;
    status_t               term;

    // End-of-run condition detection for the current RUN cycle.
    always_comb begin
        exit_hit = instr_retire && syscall && (v0 == EXIT_V0);
        halt_hit = instr_retire && halt_pc_en && (pc == halt_pc);

        loop_cnt_nxt = 32'd1;
        if (loop_vld && (pc == last_pc)) begin
            loop_cnt_nxt = (loop_cnt == CNT_MAX) ? loop_cnt : loop_cnt + 32'd1;
        end
        loop_hit = instr_retire && (SELF_LOOP_LIMIT != 0) && (loop_cnt_nxt == LOOP_LIM);

        // cycle_count still holds the pre-increment value, so this is RUN cycle TIMEOUT_CYCLES.
        tmo_hit  = (TIMEOUT_CYCLES != 0) && (cycle_count == TMO_LAST);

        term     = pick_status(exit_hit, halt_hit, loop_hit, tmo_hit);
    end

    // Next-state, status latch and output decode.
    always_comb begin
        state_nxt   = state;
        status_nxt  = status_q;
        rst_cnt_nxt = rst_cnt;
        start_acc   = 1'b0;
        in_run      = 1'b0;
        cpu_reset   = 1'b1;
        running     = 1'b0;
        done        = 1'b0;
        status      = STATUS_NONE;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc   = 1'b1;
                    state_nxt   = ST_CPU_RST;
                    rst_cnt_nxt = '0;
                    status_nxt  = STATUS_NONE;
                end
            end
            ST_CPU_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                in_run    = 1'b1;
                cpu_reset = 1'b0;
                running   = 1'b1;
                if (term != STATUS_NONE) begin
                    state_nxt  = ST_DONE;
                    status_nxt = term;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                status = status_q;
                if (start) begin
                    start_acc   = 1'b1;
                    state_nxt   = ST_CPU_RST;
                    rst_cnt_nxt = '0;
                    status_nxt  = STATUS_NONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, CPU-reset countdown and latched status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            status_q <= STATUS_NONE;
            rst_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            status_q <= status_nxt;
            rst_cnt  <= rst_cnt_nxt;
        end
    end

    // Self-loop tracker updates only on retirements inside RUN; a new run starts it fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_pc  <= '0;
            loop_vld <= 1'b0;
            loop_cnt <= '0;
        end else if (start_acc) begin
            last_pc  <= '0;
            loop_vld <= 1'b0;
            loop_cnt <= '0;
        end else if (in_run && instr_retire) begin
            last_pc  <= pc;
            loop_vld <= 1'b1;
            loop_cnt <= loop_cnt_nxt;
        end
    end

    sat_counter u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_acc),
        .enable (in_run),
        .count  (cycle_count)
    );

    sat_counter u_instr_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_acc),
        .enable (in_run && instr_retire),
        .count  (instr_count)
    );

endmodule
